// File: rtl/vp_sync_pkg.sv
// rtl/vp_sync_pkg.sv - shared state type, PAL timing defaults and width helper for vp_sync_gen
package vp_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int PAL_H_ACTIVE = 720;
    localparam int PAL_H_FP     = 12;
    localparam int PAL_H_SYNC   = 64;
    localparam int PAL_H_BP     = 68;
    localparam int PAL_V_ACTIVE = 576;
    localparam int PAL_V_FP     = 5;
    localparam int PAL_V_SYNC   = 5;
    localparam int PAL_V_BP     = 39;

    // A counter must be at least one bit wide even for degenerate totals.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vp_axis_counter.sv
// rtl/vp_axis_counter.sv - wrapping raster axis counter with region decodes
module vp_axis_counter
    import vp_sync_pkg::*;
#(
    parameter int TOTAL  = 8,
    parameter int ACTIVE = 4,
    parameter int FP     = 1,
    parameter int SYNC   = 2,
    parameter int MARK   = 0
) (
    input  logic clk,
    input  logic nReset,
    input  logic adv,
    input  logic clr,
    output logic act,
    output logic sync,
    output logic mark,
    output logic last
);

    localparam int W = cnt_width(TOTAL);

    logic [W-1:0] cnt;
    logic [31:0]  cnt32;

    assign cnt32 = 32'(cnt);
    assign act   = cnt32 < 32'(ACTIVE);
    assign sync  = (cnt32 >= 32'(ACTIVE + FP)) && (cnt32 < 32'(ACTIVE + FP + SYNC));
    assign mark  = cnt32 == 32'(MARK);
    assign last  = cnt32 == 32'(TOTAL - 1);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vp_sync_gen.sv
// rtl/vp_sync_gen.sv - Hs/Vs/De raster timing generator with registered pixel output
module vp_sync_gen
    import vp_sync_pkg::*;
#(
    parameter int   H_ACTIVE = PAL_H_ACTIVE,
    parameter int   H_FP     = PAL_H_FP,
    parameter int   H_SYNC   = PAL_H_SYNC,
    parameter int   H_BP     = PAL_H_BP,
    parameter int   V_ACTIVE = PAL_V_ACTIVE,
    parameter int   V_FP     = PAL_V_FP,
    parameter int   V_SYNC   = PAL_V_SYNC,
    parameter int   V_BP     = PAL_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       en,
    input  logic [7:0] pix_in,
    output logic       pix_req,
    output logic       Hs,
    output logic       Vs,
    output logic       De,
    output logic [7:0] vdata,
    output logic       frame_irq,
    output logic       running,
    output logic [7:0] frame_cnt
);

    localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    state_t state, state_nx;
    logic   run, frame_end;
    logic   h_act, h_sync, h_mark, h_last;
    logic   v_act, v_sync, v_mark, v_last;

    assign run       = (state != IDLE);
    assign running   = run;
    assign frame_end = h_last && v_last;
    assign pix_req   = run && h_act && v_act;

    vp_axis_counter #(
        .TOTAL(HTOT), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .MARK(0)
    ) u_hcnt (
        .clk(clk), .nReset(nReset), .adv(run), .clr(!run),
        .act(h_act), .sync(h_sync), .mark(h_mark), .last(h_last)
    );

    vp_axis_counter #(
        .TOTAL(VTOT), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .MARK(V_ACTIVE + V_FP)
    ) u_vcnt (
        .clk(clk), .nReset(nReset), .adv(run && h_last), .clr(!run),
        .act(v_act), .sync(v_sync), .mark(v_mark), .last(v_last)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Dropping en only arms the stop; the raster always runs to the frame end.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = frame_end ? IDLE : STOP;
            STOP:    if (en) state_nx = RUN;
                     else if (frame_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            De        <= 1'b0;
            vdata     <= 8'd0;
            Hs        <= ~HS_POL;
            Vs        <= ~VS_POL;
            frame_irq <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            De        <= pix_req;
            vdata     <= pix_req ? pix_in : 8'd0;
            Hs        <= (run && h_sync) ? HS_POL : ~HS_POL;
            Vs        <= (run && v_sync) ? VS_POL : ~VS_POL;
            frame_irq <= run && v_mark && h_mark;
            if (run && frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vp_sync_gen.sv
// tb/tb_vp_sync_gen.sv - randomized self-checking bench for vp_sync_gen against a raster model
module tb_vp_sync_gen;

    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       en = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_req, Hs, Vs, De, frame_irq, running;
    logic [7:0] vdata, frame_cnt;

    vp_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .nReset(nReset), .en(en), .pix_in(pix_in),
        .pix_req(pix_req), .Hs(Hs), .Vs(Vs), .De(De), .vdata(vdata),
        .frame_irq(frame_irq), .running(running), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: raster on/off plus position within the frame, and expected registered outputs.
    bit         m_on;
    int         m_pos;
    bit         e_de, e_hs, e_vs, e_irq;
    logic [7:0] e_vd;
    int         e_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_on = 0; m_pos = 0;
        e_de = 0; e_hs = 0; e_vs = 0; e_irq = 0; e_vd = 8'd0; e_fc = 0;
    endfunction

    function automatic void model_update();
        int  h, v;
        bit  act;
        h   = m_pos % HT;
        v   = m_pos / HT;
        act = m_on && h < HA && v < VA;
        e_de  = act;
        e_vd  = act ? pix_in : 8'd0;
        e_hs  = m_on && h >= HA + HF && h < HA + HF + HSW;
        e_vs  = m_on && v >= VA + VF && v < VA + VF + VSW;
        e_irq = m_on && v == VA + VF && h == 0;
        if (m_on) begin
            if (m_pos == FT - 1) begin
                e_fc++;
                if (!en) m_on = 0;
            end
            m_pos = (m_pos + 1) % FT;
        end else begin
            m_on  = en;
            m_pos = 0;
        end
    endfunction

    task automatic check_all(input string ph);
        int h, v;
        h = m_pos % HT;
        v = m_pos / HT;
        check({ph, ".pix_req"}, 32'(pix_req), 32'(m_on && h < HA && v < VA));
        check({ph, ".running"}, 32'(running), 32'(m_on));
        check({ph, ".De"}, 32'(De), 32'(e_de));
        check({ph, ".Hs"}, 32'(Hs), 32'(!e_hs));
        check({ph, ".Vs"}, 32'(Vs), 32'(!e_vs));
        check({ph, ".vdata"}, 32'(vdata), 32'(e_vd));
        check({ph, ".frame_irq"}, 32'(frame_irq), 32'(e_irq));
        check({ph, ".frame_cnt"}, 32'(frame_cnt), 32'(e_fc % 256));
    endtask

    task automatic step(input string ph, input logic en_v, input logic [7:0] px);
        check_all(ph);
        en = en_v;
        pix_in = px;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [7:0] ramp();
        return 8'(8'hA0 + m_pos % HT);
    endfunction

    task automatic pulse_reset(input string ph);
        nReset = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        check({ph, ".Hs_lvl"}, 32'(Hs), 32'd1);
        check({ph, ".Vs_lvl"}, 32'(Vs), 32'd1);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        nReset = 1'b1;

        for (int i = 0; i < 2 * FT + 4; i++) step("run", 1'b1, ramp());

        for (int i = 0; i < 10; i++) step("pre_drop", 1'b1, ramp());
        for (int i = 0; i < FT + 12; i++) step("drop", 1'b0, ramp());

        for (int i = 0; i < 10; i++) step("bounce_a", 1'b1, ramp());
        for (int i = 0; i < 10; i++) step("bounce_b", 1'b0, ramp());
        for (int i = 0; i < 2 * FT; i++) step("bounce_c", 1'b1, ramp());

        while (!(m_on && m_pos % HT == 2 && m_pos / HT == 0)) step("align", 1'b1, ramp());
        pulse_reset("midreset");
        for (int i = 0; i < FT + 8; i++) step("restart", 1'b1, ramp());

        begin
            logic e_cur;
            e_cur = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 15) == 0) e_cur = ~e_cur;
                if ($urandom_range(0, 299) == 0) pulse_reset("rnd_reset");
                step("rnd", e_cur, 8'($urandom));
            end
        end

        check_all("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vp_sync_gen.md
Name: vp_sync_gen

Overview:
- Video-port timing transmitter: generates Hs/Vs/De raster timing and a registered 8-bit pixel stream from a pixel source.
- Drives the FPGA side that the video display buffer receives and decodes, so it is the generating end of the same Hs/Vs/De interface.
- Used to feed DM642 VP capture and as a stimulus source for the buffer path.
- Single clock domain; frame-aligned start/stop; raises a frame interrupt pulse.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 12, horizontal front porch (clocks)
- H_SYNC, 64, Hs width (clocks)
- H_BP, 68, horizontal back porch (clocks)
- V_ACTIVE, 576, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, Vs width (lines)
- V_BP, 39, vertical back porch (lines)
- HS_POL, 0, Hs active level (0 = active-low)
- VS_POL, 0, Vs active level (0 = active-low)

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- nReset  in  1  asynchronous active-low reset
- en  in  1  run request; level-sensitive
- pix_in  in  8  pixel from source, valid the cycle after pix_req
- pix_req  out  1  pixel request; high one cycle ahead of De
- Hs  out  1  horizontal sync, registered, polarity HS_POL
- Vs  out  1  vertical sync, registered, polarity VS_POL
- De  out  1  data enable, registered, active-high
- vdata  out  8  registered pixel data, aligned with De
- frame_irq  out  1  one-cycle pulse at the Vs leading edge
- running  out  1  high in RUN or STOP states
- frame_cnt  out  8  completed-frame counter; wraps 255 to 0

Behaviour:
- Reset (async, immediate, also mid-frame):
  - State goes to IDLE; hcnt = 0, vcnt = 0.
  - Hs = ~HS_POL and Vs = ~VS_POL (inactive).
  - De, pix_req, vdata, frame_irq, running, frame_cnt all 0.
- Totals: HTOT = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counter widths: clog2(HTOT) for hcnt, clog2(VTOT) for vcnt.
- Counting:
  - hcnt counts 0..HTOT-1 and wraps to 0.
  - vcnt increments on the hcnt wrap and itself wraps VTOT-1 to 0.
- Region order per line: active [0, H_ACTIVE), front porch, sync, back porch. The same order applies per frame, in lines.
- Combinational decodes from the counters:
  - act = hcnt < H_ACTIVE && vcnt < V_ACTIVE
  - hs_c = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_c = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); Vs spans whole lines.
- Output timing:
  - pix_req = act && state != IDLE (combinational).
  - De, Hs, Vs are the decodes registered: latency 1 clock from the counters.
  - vdata <= pix_in when De is being set, else 0, so vdata is valid exactly while De = 1.
- frame_irq is registered high for one cycle when vcnt == V_ACTIVE+V_FP and hcnt == 0 (same cycle Vs goes active).
- State machine:
  - IDLE -> RUN when en = 1. Counters are at 0, so the first active pixel request is in the first RUN cycle.
  - RUN -> STOP when en = 0. The current frame completes.
  - STOP -> IDLE on the last clock of the frame (hcnt = HTOT-1, vcnt = VTOT-1); counters return to 0.
  - STOP -> RUN if en returns to 1 before the frame ends. There is no glitch and the raster stays continuous.
  - In IDLE the counters are held at 0 and all outputs are inactive.
- frame_cnt increments at every frame end (hcnt = HTOT-1, vcnt = VTOT-1) while in RUN or STOP.
- en toggling mid-line never truncates a line or frame; the only abort is reset.

Decomposition:
- Package vp_sync_pkg holds:
  - state enum {IDLE, RUN, STOP}
  - default PAL timing constants
  - a clog2-based width function
- One sub-module, vp_axis_counter (parameters: total, active, fp, sync):
  - counter with wrap, advance enable, clear
  - outputs: active flag, sync flag, last flag
- Instantiated twice: horizontal (advance every clock) and vertical (advance on horizontal last).

Test Plan (bench parameters: H 4/1/2/1 so HTOT = 8; V 3/1/1/1 so VTOT = 6; HS_POL = VS_POL = 0):
- Reset then en = 1 at cycle 0:
  - pix_req high cycles 0-3; De high cycles 1-4.
  - Hs low cycles 6-7; next line repeats at +8.
- Feed pix_in = 8'hA0 + hcnt:
  - vdata = A0, A1, A2, A3 while De = 1; vdata = 0 otherwise.
- Vertical timing:
  - Vs low for all 8 clocks of line 4 (cycles 33-40).
  - frame_irq is a single pulse at cycle 33.
  - frame_cnt = 1 after cycle 48.
- Drop en at cycle 10:
  - Frame completes; running falls after cycle 47.
  - Outputs are inactive afterwards; no further pix_req.
- Drop en at cycle 10, raise it at cycle 20:
  - Raster is uninterrupted; frame_cnt = 2 at cycle 96.
- Assert nReset mid-active at cycle 2:
  - De, pix_req, vdata = 0 and Hs = Vs = 1 immediately.
  - With en = 1 held, restart from hcnt = 0 after release.
